// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner with guard slots, leading-zero
// blanking and frame-synchronous value updates.
module seg7_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pval_q, pval_d;
  logic [DIGITS-1:0]     pdp_q, pdp_d;
  logic                  pblz_q, pblz_d;
  logic                  pvld_q, pvld_d;
  logic [4*DIGITS-1:0]   dval_q, dval_d;
  logic [DIGITS-1:0]     ddp_q, ddp_d;
  logic                  dblz_q, dblz_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  bnd_q;
  logic                  frame_q;

  logic                  slot_end;
  logic                  boundary;
  logic                  guard;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank;
  logic                  zrun;
  logic [DIGITS-1:0]     lzb;
  logic [DIGITS-1:0]     an_raw;
  logic [7:0]            seg_raw;

  function automatic logic [7:0] dec(input logic [3:0] n);
    dec = 8'h00;
    unique case (n)
      4'h0: dec = 8'hFC;
      4'h1: dec = 8'h60;
      4'h2: dec = 8'hDA;
      4'h3: dec = 8'hF2;
      4'h4: dec = 8'h66;
      4'h5: dec = 8'hB6;
      4'h6: dec = 8'hBE;
      4'h7: dec = 8'hE0;
      4'h8: dec = 8'hFE;
      4'h9: dec = 8'hF6;
      4'hA: dec = 8'hEE;
      4'hB: dec = 8'h3E;
      4'hC: dec = 8'h1A;
      4'hD: dec = 8'h7A;
      4'hE: dec = 8'h9E;
      4'hF: dec = 8'h8E;
    endcase
  endfunction

  assign slot_end = (cnt_q == CNT_MAX);
  assign boundary = slot_end && (idx_q == IDX_MAX);
  assign guard    = (cnt_q == '0);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (boundary)
      idx_d = '0;
    else if (slot_end)
      idx_d = idx_q + 1'b1;
  end

  // A digit is blanked while it and everything above it is zero.
  always_comb begin
    zrun = 1'b1;
    lzb  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun   = zrun & (dval_q[4*i +: 4] == 4'h0);
      lzb[i] = dblz_q & zrun & (i != 0);
    end
  end

  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    blank  = 1'b0;
    an_raw = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = dval_q[4*i +: 4];
        dp_bit    = ddp_q[i];
        blank     = lzb[i];
        an_raw[i] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_raw = blank ? 8'h00 : dec(nib);
    seg_raw[0] = dp_bit;
    seg_d = (guard ? 8'h00 : seg_raw) ^ SEG_OFF;
    an_d  = (guard ? '0 : an_raw) ^ AN_OFF;
  end

  // Loads landing on the boundary bypass pending and go live at once.
  always_comb begin
    pval_d = pval_q;
    pdp_d  = pdp_q;
    pblz_d = pblz_q;
    pvld_d = pvld_q;
    dval_d = dval_q;
    ddp_d  = ddp_q;
    dblz_d = dblz_q;
    if (boundary) begin
      pvld_d = 1'b0;
      if (load) begin
        dval_d = value;
        ddp_d  = dp_in;
        dblz_d = blank_lz;
      end else if (pvld_q) begin
        dval_d = pval_q;
        ddp_d  = pdp_q;
        dblz_d = pblz_q;
      end
    end else if (load) begin
      pval_d = value;
      pdp_d  = dp_in;
      pblz_d = blank_lz;
      pvld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pval_q  <= '0;
      pdp_q   <= '0;
      pblz_q  <= 1'b0;
      pvld_q  <= 1'b0;
      dval_q  <= '0;
      ddp_q   <= '0;
      dblz_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      bnd_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pval_q  <= pval_d;
      pdp_q   <= pdp_d;
      pblz_q  <= pblz_d;
      pvld_q  <= pvld_d;
      dval_q  <= dval_d;
      ddp_q   <= ddp_d;
      dblz_q  <= dblz_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      bnd_q   <= boundary;
      frame_q <= bnd_q;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: frame-by-frame vector table plus
// hand-written reset sequences.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;

  logic [7:0]  seg_m, seg_i, seg_1;
  logic [3:0]  an_m, an_i;
  logic [0:0]  an_1;
  logic        fr_m, fr_i, fr_1;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .DIGITS(4), .CLK_DIV(4),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_main (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .load(load),
    .seg(seg_m), .an(an_m), .frame(fr_m)
  );

  seg7_scan #(
    .DIGITS(4), .CLK_DIV(4),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_inv (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .load(load),
    .seg(seg_i), .an(an_i), .frame(fr_i)
  );

  seg7_scan #(
    .DIGITS(1), .CLK_DIV(2),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) u_one (
    .clk(clk), .rst(rst), .value(value[3:0]), .dp_in(dp_in[0:0]),
    .blank_lz(blank_lz), .load(load),
    .seg(seg_1), .an(an_1), .frame(fr_1)
  );

  // ex packs the expected lit codes {d3,d2,d1,d0} for this frame.
  typedef struct {
    logic [31:0] ex;
    int          k0;
    logic [15:0] v0;
    int          k1;
    logic [15:0] v1;
    logic [3:0]  dp;
    logic        blz;
  } rec_t;

  rec_t tbl[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_off(input string tag);
    chk({tag, " main"}, {19'd0, fr_m, an_m, seg_m}, 32'h0);
    chk({tag, " inv"}, {19'd0, fr_i, an_i, seg_i},
        {19'd0, 1'b0, 4'hF, 8'hFF});
    chk({tag, " one"}, {22'd0, fr_1, an_1, seg_1}, 32'h0);
  endtask

  task automatic run_frame(input rec_t r, input bit first, input int fi);
    int d;
    int c;
    logic [3:0] ean;
    logic [7:0] eseg;
    logic efr;
    logic ef1;
    logic [7:0] s1;
    for (int k = 0; k < 16; k++) begin
      d    = k / 4;
      c    = k % 4;
      ean  = (c == 0) ? 4'b0000 : 4'b0001 << d;
      eseg = (c == 0) ? 8'h00 : r.ex[8*d +: 8];
      efr  = (k == 0) && !first;
      ef1  = (k % 2 == 0) && !(first && k == 0);
      s1   = (k % 2 == 0) ? seg_1 : 8'h00;
      chk($sformatf("r%0d k%0d main", fi, k),
          {19'd0, fr_m, an_m, seg_m}, {19'd0, efr, ean, eseg});
      chk($sformatf("r%0d k%0d inv", fi, k),
          {19'd0, fr_i, an_i, seg_i}, {19'd0, efr, ~ean, ~eseg});
      chk($sformatf("r%0d k%0d one", fi, k),
          {22'd0, fr_1, an_1, s1},
          {22'd0, ef1, 1'(k % 2), 8'h00});
      value    = (k == r.k1) ? r.v1 : r.v0;
      dp_in    = r.dp;
      blank_lz = r.blz;
      load     = (k == r.k0) || (k == r.k1);
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    rec_t idle;
    tbl[0]  = '{32'hFCFCFCFC,  5, 16'h1A3F, -1, 16'h0, 4'b0100, 1'b0};
    tbl[1]  = '{32'h60EFF28E,  5, 16'h0040, -1, 16'h0, 4'b0000, 1'b1};
    tbl[2]  = '{32'h000066FC,  5, 16'h0000, -1, 16'h0, 4'b0000, 1'b1};
    tbl[3]  = '{32'h000000FC, 14, 16'h8888, -1, 16'h0, 4'b0000, 1'b0};
    tbl[4]  = '{32'hFEFEFEFE, -1, 16'h0000, -1, 16'h0, 4'b0000, 1'b0};
    tbl[5]  = '{32'hFEFEFEFE,  2, 16'h2222, 10, 16'h1111, 4'b0000, 1'b0};
    tbl[6]  = '{32'h60606060, -1, 16'h0000, -1, 16'h0, 4'b0000, 1'b0};
    tbl[7]  = '{32'h60606060,  5, 16'h0005, -1, 16'h0, 4'b1000, 1'b1};
    tbl[8]  = '{32'h010000B6,  5, 16'h7654, -1, 16'h0, 4'b0000, 1'b0};
    tbl[9]  = '{32'hE0BEB666,  5, 16'hBA98, -1, 16'h0, 4'b0000, 1'b0};
    tbl[10] = '{32'h3EEEF6FE,  5, 16'hFEDC, -1, 16'h0, 4'b0000, 1'b0};
    tbl[11] = '{32'h8E9E7A1A,  5, 16'h0201, -1, 16'h0, 4'b0000, 1'b1};
    tbl[12] = '{32'h00DAFC60, -1, 16'h0000, -1, 16'h0, 4'b0000, 1'b0};
    idle    = '{32'hFCFCFCFC, -1, 16'h0000, -1, 16'h0, 4'b0000, 1'b0};

    rst      = 1'b1;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    load     = 1'b0;
    step();
    step();
    chk_off("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++)
      run_frame(tbl[i], i == 0, i);

    // Leave a load pending, then reset in the middle of digit 2.
    value = 16'h8888;
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();
    chk("pre-rst main", {20'd0, an_m, seg_m}, {20'd0, 4'b0100, 8'hDA});
    rst = 1'b1;
    step();
    chk_off("midrst");
    rst = 1'b0;
    step();
    run_frame(idle, 1'b1, 100);
    run_frame(idle, 1'b0, 101);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
